// File: rtl/multiplexer_route_ctrl.sv
// Break-before-make route sequencer for a 2^LEVELS-leaf binary-tree fluidic multiplexer.
// Optional macro MUX_HOLD_TIMEOUT_EN adds HOLD_CYCLES and the timeout_pulse output.
module multiplexer_route_ctrl #(
  parameter int unsigned LEVELS        = 5,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
`ifdef MUX_HOLD_TIMEOUT_EN
  ,
  parameter int unsigned HOLD_CYCLES   = 200
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sel_valid,
  output logic                sel_ready,
  input  logic [LEVELS-1:0]   sel_index,
  input  logic                release_req,
  output logic [2*LEVELS-1:0] c_close,
  output logic                route_active,
  output logic                busy
`ifdef MUX_HOLD_TIMEOUT_EN
  ,
  output logic                timeout_pulse
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
`ifdef MUX_HOLD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEVELS-1:0]   idx_q, idx_d;
  logic [2*LEVELS-1:0] path_d;
  logic [2*LEVELS-1:0] c_close_d;
  logic                tpulse_d;

  assign sel_ready = (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tpulse_d = 1'b0;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel_valid) begin
          idx_d   = sel_index;
          state_d = OPEN;
        end
      end
      OPEN: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        // release_req takes priority over the hold timeout in the same cycle
        if (release_req) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
`ifdef MUX_HOLD_TIMEOUT_EN
        else if (cnt_q == HOLD_LAST) begin
          state_d  = DRAIN;
          cnt_d    = '0;
          tpulse_d = 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Level L is steered by index bit LEVELS-L (MSB selects at level 1); 0 = open.
  always_comb begin
    path_d = '1;
    for (int unsigned l = 1; l <= LEVELS; l++) begin
      path_d[2*(l-1)]   = idx_d[LEVELS-l];
      path_d[2*(l-1)+1] = ~idx_d[LEVELS-l];
    end
  end

  always_comb begin
    c_close_d = '1;
    if (state_d == OPEN || state_d == ACTIVE) begin
      c_close_d = path_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      c_close      <= '1;
      route_active <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      c_close      <= c_close_d;
      route_active <= (state_d == ACTIVE);
      busy         <= (state_d != IDLE);
    end
  end

`ifdef MUX_HOLD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= tpulse_d;
    end
  end
`else
  logic unused_tpulse;
  assign unused_tpulse = tpulse_d;
`endif

endmodule
